// File: rtl/floo_link_buffer.sv
// Elastic link FIFO for one NoC channel: registered output, ready decoupled from out_ready_i.
// Optional per-entry even parity with a sticky error flag when FLOO_LINK_BUFFER_PARITY_EN is defined.
module floo_link_buffer #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned Depth     = 4,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [DataWidth-1:0]         in_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [DataWidth-1:0]         out_data_o,
  output logic [$clog2(Depth+1)-1:0]   usage_o,
  output logic [CntWidth-1:0]          stall_cnt_o,
  output logic [CntWidth-1:0]          xfer_cnt_o,
  input  logic                         clr_cnt_i,
  output logic                         parity_err_o
);
  localparam int unsigned UsageW = $clog2(Depth + 1);
  localparam int unsigned PtrW   = $clog2(Depth);

  typedef logic [PtrW-1:0] ptr_t;

  logic [DataWidth-1:0] mem [Depth];
  ptr_t                 wptr, rptr;
  logic [UsageW-1:0]    cnt;
  logic [CntWidth-1:0]  stall_cnt, xfer_cnt;
  logic                 push, pop;

  // Explicit wrap so non-power-of-two depths work.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(Depth - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign in_ready_o  = (cnt != UsageW'(Depth)) & ~rst_i;
  assign out_valid_o = (cnt != '0);
  assign out_data_o  = mem[rptr];
  assign usage_o     = cnt;
  assign stall_cnt_o = stall_cnt;
  assign xfer_cnt_o  = xfer_cnt;

  assign push = in_valid_i & in_ready_o;
  assign pop  = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + UsageW'(1);
        2'b01:   cnt <= cnt - UsageW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset; only the pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= in_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_cnt_i) begin
      stall_cnt <= '0;
      xfer_cnt  <= '0;
    end else begin
      if (out_valid_o && !out_ready_i && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CntWidth'(1);
      if (pop)
        xfer_cnt <= xfer_cnt + CntWidth'(1);
    end
  end

`ifdef FLOO_LINK_BUFFER_PARITY_EN
  logic par [Depth];
  logic par_err;

  always_ff @(posedge clk_i) begin
    if (push) par[wptr] <= ^in_data_i;
  end

  // Sticky until reset; the flit itself is forwarded untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      par_err <= 1'b0;
    else if (pop && ((^mem[rptr]) != par[rptr]))
      par_err <= 1'b1;
  end

  assign parity_err_o = par_err;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_floo_link_buffer.sv
// Directed plus randomized bench for floo_link_buffer against a queue-based reference model.
module tb_floo_link_buffer;
  localparam int DW = 64;
  localparam int DEPTH = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_i, in_valid_i, out_ready_i, clr_cnt_i;
  logic [DW-1:0] in_data_i;
  logic          in_ready_o, out_valid_o, parity_err_o;
  logic [DW-1:0] out_data_o;
  logic [2:0]    usage_o;
  logic [CW-1:0] stall_cnt_o, xfer_cnt_o;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [DW-1:0] q[$];
  int            m_stall = 0;
  int            m_xfer  = 0;
  logic          m_perr  = 1'b0;

  floo_link_buffer #(.DataWidth(DW), .Depth(DEPTH), .CntWidth(CW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .usage_o(usage_o), .stall_cnt_o(stall_cnt_o), .xfer_cnt_o(xfer_cnt_o),
    .clr_cnt_i(clr_cnt_i), .parity_err_o(parity_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs after negedge, check outputs vs model, advance model at posedge.
  task automatic cycle(input logic iv, input logic [DW-1:0] id, input logic ordy,
                       input logic clr, input logic rst);
    logic e_valid, e_ready, do_push, do_pop;
    in_valid_i = iv; in_data_i = id; out_ready_i = ordy; clr_cnt_i = clr; rst_i = rst;
    #1;
    e_valid = (q.size() != 0);
    e_ready = (q.size() != DEPTH) && !rst;
    chk("out_valid", DW'(out_valid_o), DW'(e_valid));
    chk("in_ready", DW'(in_ready_o), DW'(e_ready));
    chk("usage", DW'(usage_o), DW'(q.size()));
    chk("stall_cnt", DW'(stall_cnt_o), DW'(m_stall));
    chk("xfer_cnt", DW'(xfer_cnt_o), DW'(m_xfer));
    chk("parity_err", DW'(parity_err_o), DW'(m_perr));
    if (e_valid) chk("out_data", out_data_o, q[0]);
    do_push = iv && e_ready;
    do_pop  = e_valid && ordy;
    @(posedge clk);
    if (rst) begin
      q.delete(); m_stall = 0; m_xfer = 0; m_perr = 1'b0;
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(id);
      if (clr) begin
        m_stall = 0; m_xfer = 0;
      end else begin
        if (e_valid && !ordy && m_stall < 65535) m_stall++;
        if (do_pop) m_xfer = (m_xfer + 1) % 65536;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst_i = 1'b1; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0; clr_cnt_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // reset held: outputs quiet, ready low
    cycle(0, '0, 0, 0, 1);
    // idle after release
    cycle(0, '0, 0, 0, 0);
    chk("idle_ready", DW'(in_ready_o), DW'(1));

    // single flit A5, one-cycle latency
    cycle(1, 64'hA5, 1, 0, 0);
    #1 chk("a5_visible", out_data_o, 64'hA5);
    cycle(0, '0, 1, 0, 0);
    cycle(0, '0, 0, 0, 0);
    chk("a5_xfer", DW'(xfer_cnt_o), 64'd1);

    // fill with back-pressure
    cycle(0, '0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) cycle(1, DW'(i), 0, 0, 0);
    cycle(1, 64'h5, 0, 0, 0);
    chk("full_usage", DW'(usage_o), 64'd4);
    chk("full_stall", DW'(stall_cnt_o), 64'd4);
    // full with downstream ready: still not ready this cycle
    #1 chk("full_ready_pop", DW'(in_ready_o), 64'd0);
    cycle(1, 64'h5, 1, 0, 0);
    #1 chk("ready_after_pop", DW'(in_ready_o), 64'd1);
    for (int i = 0; i < 6; i++) cycle(i == 0, 64'h5, 1, 0, 0);

    // 100-flit stream, no bubbles after the first
    cycle(0, '0, 1, 1, 0);
    for (int i = 0; i < 100; i++) begin
      if (i > 0) chk("stream_nobubble", DW'(out_valid_o), 64'd1);
      cycle(1, DW'(64'h1000 + i), 1, 0, 0);
    end
    cycle(0, '0, 1, 0, 0);
    chk("stream_xfer", DW'(xfer_cnt_o), 64'd100);

    // mid-operation reset with 3 queued
    for (int i = 0; i < 3; i++) cycle(1, DW'(64'h300 + i), 0, 0, 0);
    chk("pre_rst_usage", DW'(usage_o), 64'd3);
    cycle(1, 64'hDEAD, 0, 0, 1);
    chk("post_rst_usage", DW'(usage_o), 64'd0);
    chk("post_rst_valid", DW'(out_valid_o), 64'd0);
    chk("post_rst_stall", DW'(stall_cnt_o), 64'd0);
    cycle(1, 64'h77, 0, 0, 0);
    #1 chk("first_after_rst", out_data_o, 64'h77);
    cycle(0, '0, 1, 0, 0);

`ifdef FLOO_LINK_BUFFER_PARITY_EN
    cycle(0, '0, 0, 0, 1);
    cycle(1, 64'h0F0F, 0, 0, 0);
    dut.mem[0][3] = ~dut.mem[0][3];
    q[0][3] = ~q[0][3];
    cycle(0, '0, 1, 0, 0);
    m_perr = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1, DW'(i), 1, 0, 0);
    chk("parity_sticky", DW'(parity_err_o), 64'd1);
    cycle(0, '0, 0, 0, 1);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 2) != 0),
            $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0);
    end
    cycle(0, '0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
